// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and register-id defaults.
// Also holds the W-latch control record used by the write-back stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  localparam int RNONE_DEF = 15;
  localparam int RSP_DEF   = 4;

  typedef struct packed {
    logic       valid;
    logic [3:0] icode;
    logic       cnd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] stat;
  } w_ctl_t;

  // A bubble is a non-valid NOP whose register fields name no register.
  function automatic w_ctl_t w_bubble_ctl();
    w_ctl_t c;
    c.valid = 1'b0;
    c.icode = INOP;
    c.cnd   = 1'b0;
    c.ra    = 4'(RNONE_DEF);
    c.rb    = 4'(RNONE_DEF);
    c.stat  = SAOK;
    return c;
  endfunction

endpackage

// File: rtl/wb_dst_decode.sv
// Pure combinational destination decode: icode/cnd/rA/rB -> dstE/dstM.
// Shared with the pipelined forwarding logic, so it carries no state.
module wb_dst_decode
  import y86_pkg::*;
#(
  parameter int RNONE = RNONE_DEF,
  parameter int RSP   = RSP_DEF
) (
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = 4'(RNONE);
    dst_m = 4'(RNONE);
    case (icode)
      IRRMOVQ: if (cnd) dst_e = rb;
      IIRMOVQ,
      IOPQ:    dst_e = rb;
      IMRMOVQ: dst_m = ra;
      ICALL,
      IRET,
      IPUSHQ:  dst_e = 4'(RSP);
      IPOPQ: begin
        dst_e = 4'(RSP);
        dst_m = ra;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: W latch, destination decode, two-write/two-read register file
// with commit bypass, sticky halt and a retired-instruction counter.
module wb_regfile_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RNONE  = RNONE_DEF,
  parameter int RSP    = RSP_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [3:0]        m_rA,
  input  logic [3:0]        m_rB,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [1:0]        m_stat,
  input  logic              w_stall,
  input  logic              w_bubble,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        w_dstE,
  output logic [3:0]        w_dstM,
  output logic [DATA_W-1:0] w_valE,
  output logic [DATA_W-1:0] w_valM,
  output logic              retire,
  output logic              halted,
  output logic [1:0]        stat_out,
  output logic [CNT_W-1:0]  instr_cnt
);

  // Latch control: w_bubble clears the W latch, else w_stall holds it, else it
  // loads the M stage; m_valid marks whether the loaded entry is an instruction.
  w_ctl_t            w_ctl;
  logic [DATA_W-1:0] regs [NREG];
  logic              commit, wr_ok, we_e, we_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ctl  <= w_bubble_ctl();
      w_valE <= '0;
      w_valM <= '0;
    end else if (w_bubble) begin
      w_ctl  <= w_bubble_ctl();
      w_valE <= '0;
      w_valM <= '0;
    end else if (!w_stall) begin
      w_ctl  <= '{valid: m_valid, icode: m_icode, cnd: m_cnd,
                  ra: m_rA, rb: m_rB, stat: m_stat};
      w_valE <= m_valE;
      w_valM <= m_valM;
    end
  end

  wb_dst_decode #(.RNONE(RNONE), .RSP(RSP)) u_dst_decode (
    .icode (w_ctl.icode),
    .cnd   (w_ctl.cnd),
    .ra    (w_ctl.ra),
    .rb    (w_ctl.rb),
    .dst_e (w_dstE),
    .dst_m (w_dstM)
  );

  function automatic logic in_range(input logic [3:0] id);
    return (id != 4'(RNONE)) && (int'(id) < NREG);
  endfunction

  assign commit = w_ctl.valid && !halted;
  assign retire = commit;
  assign wr_ok  = commit && (w_ctl.stat == SAOK);
  assign we_e   = wr_ok && in_range(w_dstE);
  assign we_m   = wr_ok && in_range(w_dstM);

  // The M write comes second so it wins when both target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (we_e) regs[w_dstE] <= w_valE;
      if (we_m) regs[w_dstM] <= w_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted    <= 1'b0;
      stat_out  <= SAOK;
      instr_cnt <= '0;
    end else if (commit) begin
      instr_cnt <= instr_cnt + 1'b1;
      stat_out  <= w_ctl.stat;
      if (w_ctl.stat != SAOK) halted <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] id);
    if (!in_range(id))                return '0;
    else if (we_m && (w_dstM == id))  return w_valM;
    else if (we_e && (w_dstE == id))  return w_valE;
    else                              return regs[id];
  endfunction

  always_comb begin
    valA = read_port(srcA);
    valB = read_port(srcB);
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage with hand-computed expectations
// (CNT_W=4 so the counter wrap is reachable).
module tb_wb_regfile_stage;
  import y86_pkg::*;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_valid, m_cnd, w_stall, w_bubble;
  logic [3:0]    m_icode, m_rA, m_rB, srcA, srcB;
  logic [DW-1:0] m_valE, m_valM;
  logic [1:0]    m_stat;
  logic [DW-1:0] valA, valB, w_valE, w_valM;
  logic [3:0]    w_dstE, w_dstM;
  logic          retire, halted;
  logic [1:0]    stat_out;
  logic [CW-1:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_regs [16];

  wb_regfile_stage #(.DATA_W(DW), .NREG(15), .RNONE(15), .RSP(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd),
    .m_rA(m_rA), .m_rB(m_rB), .m_valE(m_valE), .m_valM(m_valM), .m_stat(m_stat),
    .w_stall(w_stall), .w_bubble(w_bubble), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .w_dstE(w_dstE), .w_dstM(w_dstM),
    .w_valE(w_valE), .w_valM(w_valM), .retire(retire), .halted(halted),
    .stat_out(stat_out), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic [3:0] icode, input logic cnd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [1:0] st);
    m_valid = 1'b1; m_icode = icode; m_cnd = cnd; m_rA = ra; m_rB = rb;
    m_valE = ve; m_valM = vm; m_stat = st;
  endtask

  task automatic drive_idle();
    m_valid = 1'b0; m_icode = INOP; m_cnd = 1'b0; m_rA = 4'hF; m_rB = 4'hF;
    m_valE = '0; m_valM = '0; m_stat = SAOK;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] id, input logic [63:0] exp);
    srcA = id;
    #1;
    check(tag, valA, exp);
  endtask

  task automatic chk_b(input string tag, input logic [3:0] id, input logic [63:0] exp);
    srcB = id;
    #1;
    check(tag, valB, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    drive_idle();
    w_stall = 1'b0; w_bubble = 1'b0; srcA = 4'd2; srcB = 4'd0;
    #12;
    check("rst_retire", {63'd0, retire}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_stat", {62'd0, stat_out}, 64'd0);
    check("rst_cnt", {60'd0, instr_cnt}, 64'd0);
    check("rst_dste", {60'd0, w_dstE}, 64'd15);
    check("rst_dstm", {60'd0, w_dstM}, 64'd15);
    check("rst_vala", valA, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // irmovq $0x1234, %rdx
    drive_m(IIRMOVQ, 1'b0, 4'hF, 4'd2, 64'h1234, 64'h0, SAOK);
    step();
    drive_idle();
    check("irm_retire", {63'd0, retire}, 64'd1);
    check("irm_dste", {60'd0, w_dstE}, 64'd2);
    check("irm_dstm", {60'd0, w_dstM}, 64'd15);
    chk_a("irm_bypass", 4'd2, 64'h1234);
    step();
    exp_regs[2] = 64'h1234;
    check("irm_cnt", {60'd0, instr_cnt}, 64'd1);
    check("irm_retire_off", {63'd0, retire}, 64'd0);
    chk_a("irm_reg2", 4'd2, 64'h1234);

    // cmovXX not taken, then taken
    drive_m(IRRMOVQ, 1'b0, 4'd2, 4'd5, 64'd7, 64'h0, SAOK);
    step();
    drive_idle();
    check("cmovn_dste", {60'd0, w_dstE}, 64'd15);
    check("cmovn_retire", {63'd0, retire}, 64'd1);
    step();
    chk_b("cmovn_reg5", 4'd5, 64'd0);
    check("cmovn_cnt", {60'd0, instr_cnt}, 64'd2);
    drive_m(IRRMOVQ, 1'b1, 4'd2, 4'd5, 64'd7, 64'h0, SAOK);
    step();
    drive_idle();
    step();
    exp_regs[5] = 64'd7;
    chk_b("cmovt_reg5", 4'd5, 64'd7);

    // popq %rsp: M beats E on the same id, both in the bypass and the write
    drive_m(IPOPQ, 1'b0, 4'd4, 4'hF, 64'h100, 64'h200, SAOK);
    step();
    drive_idle();
    check("poprsp_dste", {60'd0, w_dstE}, 64'd4);
    check("poprsp_dstm", {60'd0, w_dstM}, 64'd4);
    chk_a("poprsp_bypass", 4'd4, 64'h200);
    step();
    chk_a("poprsp_reg4", 4'd4, 64'h200);

    // popq %rbx
    drive_m(IPOPQ, 1'b0, 4'd3, 4'hF, 64'h100, 64'h200, SAOK);
    step();
    drive_idle();
    chk_b("poprbx_bypass_e", 4'd4, 64'h100);
    chk_a("poprbx_bypass_m", 4'd3, 64'h200);
    step();
    chk_a("poprbx_reg4", 4'd4, 64'h100);
    chk_a("poprbx_reg3", 4'd3, 64'h200);

    // mrmovq into %rsi (valE must be ignored), then call (valE to %rsp)
    drive_m(IMRMOVQ, 1'b0, 4'd6, 4'd1, 64'h55, 64'hABCD, SAOK);
    step();
    drive_m(ICALL, 1'b0, 4'hF, 4'hF, 64'hF8, 64'h0, SAOK);
    step();
    drive_idle();
    step();
    exp_regs[3] = 64'h200; exp_regs[4] = 64'hF8; exp_regs[6] = 64'hABCD;
    check("call_cnt", {60'd0, instr_cnt}, 64'd7);
    chk_a("rnone_read", 4'd15, 64'd0);

    // Register file sweep through the expected queue
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_regs[i]);
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      chk_b($sformatf("sweep_r%0d", i), 4'(i), e);
    end
    step();

    // Stall with W empty: nothing retires and the pending M instruction waits
    drive_m(IIRMOVQ, 1'b0, 4'hF, 4'd7, 64'h77, 64'h0, SAOK);
    w_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_retire_%0d", i), {63'd0, retire}, 64'd0);
    end
    check("stall_cnt", {60'd0, instr_cnt}, 64'd7);
    w_bubble = 1'b1;
    step();
    check("bub_dste", {60'd0, w_dstE}, 64'd15);
    check("bub_dstm", {60'd0, w_dstM}, 64'd15);
    check("bub_retire", {63'd0, retire}, 64'd0);
    w_bubble = 1'b0; w_stall = 1'b0;
    step();
    drive_idle();
    check("unstall_dste", {60'd0, w_dstE}, 64'd7);
    check("unstall_retire", {63'd0, retire}, 64'd1);
    step();
    check("unstall_cnt", {60'd0, instr_cnt}, 64'd8);
    chk_a("unstall_reg7", 4'd7, 64'h77);

    // Halt: non-AOK irmovq commits its status but writes nothing
    drive_m(IIRMOVQ, 1'b0, 4'hF, 4'd8, 64'h88, 64'h0, SHLT);
    step();
    drive_idle();
    check("hlt_retire", {63'd0, retire}, 64'd1);
    chk_a("hlt_no_bypass", 4'd8, 64'd0);
    step();
    check("hlt_halted", {63'd0, halted}, 64'd1);
    check("hlt_stat", {62'd0, stat_out}, 64'd1);
    check("hlt_cnt", {60'd0, instr_cnt}, 64'd9);
    chk_a("hlt_reg8", 4'd8, 64'd0);
    drive_m(IIRMOVQ, 1'b0, 4'hF, 4'd9, 64'h99, 64'h0, SAOK);
    step();
    drive_idle();
    check("post_hlt_dste", {60'd0, w_dstE}, 64'd9);
    check("post_hlt_retire", {63'd0, retire}, 64'd0);
    step();
    chk_a("post_hlt_reg9", 4'd9, 64'd0);
    check("post_hlt_cnt", {60'd0, instr_cnt}, 64'd9);
    chk_a("post_hlt_read7", 4'd7, 64'h77);

    // Asynchronous reset between clock edges
    step();
    rst_n = 1'b0;
    #2;
    check("arst_halted", {63'd0, halted}, 64'd0);
    check("arst_cnt", {60'd0, instr_cnt}, 64'd0);
    check("arst_stat", {62'd0, stat_out}, 64'd0);
    chk_a("arst_reg7", 4'd7, 64'd0);
    step();
    rst_n = 1'b1;

    // Reset during a pending commit discards it
    drive_m(IIRMOVQ, 1'b0, 4'hF, 4'd10, 64'hAA, 64'h0, SAOK);
    step();
    drive_idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_a("rstmid_reg10", 4'd10, 64'd0);
    check("rstmid_cnt", {60'd0, instr_cnt}, 64'd0);

    // 17 back-to-back commits wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive_m(IIRMOVQ, 1'b0, 4'hF, 4'd1, 64'(i + 1), 64'h0, SAOK);
      step();
    end
    drive_idle();
    step();
    check("wrap_cnt", {60'd0, instr_cnt}, 64'd1);
    chk_a("wrap_reg1", 4'd1, 64'd17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
